// File: rtl/ps4_client.sv
// Client side of the ps4 fixed-priority selector: pending-job counters, request/enable drive,
// grant legality check and fixed-length burst sequencing. Optional req backoff: PS4_CLIENT_BACKOFF_EN.
module ps4_client #(
    parameter int BURST = 4,
    parameter int CNT_W = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] push,
    output logic [3:0] req,
    output logic       arb_en,
    input  logic [3:0] gnt,
    output logic [3:0] owner,
    output logic       beat,
    output logic [3:0] done,
    output logic [3:0] ovf,
    output logic       err
);
    localparam int BW = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [BW-1:0]    LAST = BW'(BURST - 1);
    localparam logic [CNT_W-1:0] PMAX = '1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                  state_q;
    logic [3:0][CNT_W-1:0]   pend_q, pend_d;
    logic [3:0]              req_q, req_d, nz_d, mask;
    logic [3:0]              owner_q, done_q, done_d, ovf_q, ovf_set;
    logic [BW-1:0]           cnt_q;
    logic                    beat_q, err_q, err_hit;
    logic                    gnt_legal, accept, finish;

    assign arb_en    = (state_q == IDLE) && (req_q != 4'b0);
    // Legal grant: exactly one bit, on a requesting client, while enabled.
    assign gnt_legal = arb_en && (gnt != 4'b0) && ((gnt & (gnt - 4'd1)) == 4'b0)
                       && ((gnt & ~req_q) == 4'b0);
    assign accept    = (state_q == IDLE) && gnt_legal;
    assign finish    = (state_q == BUSY) && (cnt_q == '0);
    assign err_hit   = (gnt != 4'b0) && ((state_q == BUSY) || !gnt_legal);

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pend_d[i]  = pend_q[i];
            ovf_set[i] = 1'b0;
            if (push[i] && !(accept && gnt[i])) begin
                if (pend_q[i] == PMAX) ovf_set[i] = 1'b1;
                else                   pend_d[i]  = pend_q[i] + CNT_W'(1);
            end else if (!push[i] && accept && gnt[i]) begin
                pend_d[i] = pend_q[i] - CNT_W'(1);
            end
            nz_d[i] = (pend_d[i] != '0);
        end
    end

`ifdef PS4_CLIENT_BACKOFF_EN
    // Hide the just-served client for one arbitration cycle when someone else is waiting.
    assign mask = (finish && ((nz_d & ~owner_q) != 4'b0)) ? owner_q : 4'b0;
`else
    assign mask = 4'b0;
`endif
    assign req_d = nz_d & ~mask;

    always_comb begin
        done_d = 4'b0;
        if (accept && (BURST == 1))                     done_d = gnt;
        else if ((state_q == BUSY) && (cnt_q == BW'(1))) done_d = owner_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= '0;
            req_q   <= 4'b0;
            owner_q <= 4'b0;
            cnt_q   <= '0;
            beat_q  <= 1'b0;
            done_q  <= 4'b0;
            ovf_q   <= 4'b0;
            err_q   <= 1'b0;
        end else begin
            pend_q <= pend_d;
            req_q  <= req_d;
            done_q <= done_d;
            ovf_q  <= ovf_q | ovf_set;
            err_q  <= err_q | err_hit;
            case (state_q)
                IDLE: if (accept) begin
                    owner_q <= gnt;
                    cnt_q   <= LAST;
                    beat_q  <= 1'b1;
                    state_q <= BUSY;
                end
                BUSY: if (finish) begin
                    owner_q <= 4'b0;
                    beat_q  <= 1'b0;
                    state_q <= IDLE;
                end else begin
                    cnt_q <= cnt_q - BW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req   = req_q;
    assign owner = owner_q;
    assign beat  = beat_q;
    assign done  = done_q;
    assign ovf   = ovf_q;
    assign err   = err_q;
endmodule

// File: tb/tb_ps4_client.sv
// Directed bench for ps4_client with a behavioural fixed-priority selector and an
// expected-owner scoreboard checked at the start of every burst.
module tb_ps4_client;
    localparam int BURST = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] push  = 4'b0;
    logic [3:0] req, gnt, owner, done, ovf;
    logic       arb_en, beat, err;
    logic       force_en = 1'b0;
    logic [3:0] force_val = 4'b0;

    int         vecs = 0;
    int         mis  = 0;
    int         cyc  = 0;
    logic [3:0] expq[$];

    ps4_client #(.BURST(BURST), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .push(push), .req(req), .arb_en(arb_en),
        .gnt(gnt), .owner(owner), .beat(beat), .done(done), .ovf(ovf), .err(err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Selector model: fixed priority 3>2>1>0, overridable to inject grants.
    always_comb begin
        gnt = 4'b0;
        if (force_en)    gnt = force_val;
        else if (arb_en) begin
            if      (req[3]) gnt = 4'b1000;
            else if (req[2]) gnt = 4'b0100;
            else if (req[1]) gnt = 4'b0010;
            else if (req[0]) gnt = 4'b0001;
        end
    end

    task automatic step;
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp)
        else begin
            mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for a burst, checks owner against the scoreboard, length and done pulse,
    // then steps into the following idle cycle. p is pushed on the first beat.
    task automatic run_burst(input string tag, input logic [3:0] p, output int last_cyc);
        int n;
        int k;
        logic [3:0] e;
        n = 0;
        while (beat !== 1'b1 && n < 50) begin step; n++; end
        check({tag, "_start"}, {31'b0, beat}, 32'd1);
        e = (expq.size() != 0) ? expq.pop_front() : 4'hx;
        check({tag, "_owner"}, {28'b0, owner}, {28'b0, e});
        push = p;
        k = 1;
        while (done === 4'b0 && k < 20) begin
            step;
            push = 4'b0;
            k++;
        end
        push = 4'b0;
        check({tag, "_done"}, {28'b0, done}, {28'b0, e});
        check({tag, "_len"}, k, BURST);
        last_cyc = cyc;
        step;
    endtask

    initial begin
        int t0;
        int t1;
        int n;

        // Reset state
        step; step;
        check("rst_req", {28'b0, req}, 0);
        check("rst_arb_en", {31'b0, arb_en}, 0);
        check("rst_owner", {28'b0, owner}, 0);
        check("rst_beat", {31'b0, beat}, 0);
        check("rst_done", {28'b0, done}, 0);
        check("rst_ovf", {28'b0, ovf}, 0);
        check("rst_err", {31'b0, err}, 0);
        reset = 1'b0;
        step;

        // Single push on client 2: req next cycle, first beat one cycle later
        push = 4'b0100;
        step;
        push = 4'b0;
        check("t1_req", {28'b0, req}, 32'h4);
        check("t1_arb_en", {31'b0, arb_en}, 1);
        expq.push_back(4'b0100);
        step;
        check("t1_beat_lat", {31'b0, beat}, 1);
        run_burst("t1", 4'b0, t1);
        check("t1_req_after", {28'b0, req}, 0);
        check("t1_idle", {31'b0, beat}, 0);

        // All four clients at once: served 3,2,1,0 in 19 cycles from first beat
        push = 4'b1111;
        step;
        push = 4'b0;
        expq.push_back(4'b1000); expq.push_back(4'b0100);
        expq.push_back(4'b0010); expq.push_back(4'b0001);
        n = 0;
        while (beat !== 1'b1 && n < 10) begin step; n++; end
        t0 = cyc;
        for (int b = 0; b < 4; b++) run_burst("t2", 4'b0, t1);
        check("t2_span", t1 - t0 + 1, 19);
        check("t2_err", {31'b0, err}, 0);

        // Saturation: grants held off while client 0 gets 8 pushes
        force_en = 1'b1; force_val = 4'b0;
        push = 4'b0001;
        for (int i = 0; i < 7; i++) step;
        check("t3_ovf_at7", {28'b0, ovf}, 0);
        step;
        push = 4'b0;
        check("t3_ovf", {28'b0, ovf}, 32'h1);
        check("t3_err", {31'b0, err}, 0);
        force_en = 1'b0;
        for (int i = 0; i < 7; i++) expq.push_back(4'b0001);
        for (int i = 0; i < 7; i++) run_burst("t3", 4'b0, t1);
        n = 0;
        for (int i = 0; i < 10; i++) begin step; if (beat) n++; end
        check("t3_no_extra", n, 0);
        check("t3_req_after", {28'b0, req}, 0);

        // Multi-hot grant: err, no burst; next legal grant accepted
        force_en = 1'b1; force_val = 4'b0;
        push = 4'b0011;
        step;
        push = 4'b0;
        check("t4_req", {28'b0, req}, 32'h3);
        force_val = 4'b0011;
        step;
        force_val = 4'b0;
        check("t4_err", {31'b0, err}, 1);
        check("t4_beat", {31'b0, beat}, 0);
        check("t4_owner", {28'b0, owner}, 0);
        force_en = 1'b0;
        expq.push_back(4'b0010); expq.push_back(4'b0001);
        run_burst("t4a", 4'b0, t1);
        run_burst("t4b", 4'b0, t1);
        check("t4_err_sticky", {31'b0, err}, 1);

        // Reset on beat 2 aborts the burst at once
        push = 4'b1000;
        step;
        push = 4'b0;
        n = 0;
        while (beat !== 1'b1 && n < 10) begin step; n++; end
        check("t5_owner", {28'b0, owner}, 32'h8);
        step;
        reset = 1'b1;
        #1;
        check("t5_all", {req, 3'b0, arb_en, owner, 3'b0, beat, done, ovf, 3'b0, err}, 0);
        step;
        reset = 1'b0;
        step; step;
        check("t5_req_after", {28'b0, req}, 0);
        check("t5_beat_after", {31'b0, beat}, 0);

        // Client 3 re-pushes during its bursts while client 0 waits
        push = 4'b1001;
        step;
        push = 4'b0;
`ifdef PS4_CLIENT_BACKOFF_EN
        expq.push_back(4'b1000); expq.push_back(4'b0001); expq.push_back(4'b1000);
        expq.push_back(4'b1000); expq.push_back(4'b1000);
`else
        expq.push_back(4'b1000); expq.push_back(4'b1000); expq.push_back(4'b1000);
        expq.push_back(4'b1000); expq.push_back(4'b0001);
`endif
        for (int b = 0; b < 3; b++) run_burst("t6_push", 4'b1000, t1);
        run_burst("t6_tail_a", 4'b0, t1);
        run_burst("t6_tail_b", 4'b0, t1);
        check("t6_sb_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, mis);
        $finish;
    end
endmodule
